// File: rtl/fifo_sync_prog_dp.sv
// Single-clock parametrised FIFO data path with programmable almost-full/empty
// thresholds, occupancy count, optional FWFT read, flush and sticky error status.
module fifo_sync_prog_dp #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4,
    parameter bit          fwft_mode  = 1'b0
) (
    input  logic                  clk_dp,
    input  logic                  rst_n_in_dp,
    input  logic [data_width-1:0] data_in_dp,
    input  logic                  wt_en_dp,
    input  logic                  rd_en_dp,
    input  logic                  flush_dp,
    input  logic                  err_clr_dp,
    input  logic [addr_width:0]   af_thresh_dp,
    input  logic [addr_width:0]   ae_thresh_dp,
    output logic [data_width-1:0] data_out_dp,
    output logic [addr_width:0]   fill_count_dp,
    output logic                  full_st_dp,
    output logic                  empty_st_dp,
    output logic                  almost_full_dp,
    output logic                  almost_empty_dp,
    output logic                  push_on_full_error_dp,
    output logic                  pop_on_empty_error_dp,
    output logic                  overflow_sticky_dp,
    output logic                  underflow_sticky_dp
);

    localparam int unsigned depth = 2 ** addr_width;
    localparam int unsigned cnt_w = addr_width + 1;

    logic [data_width-1:0] mem [depth];
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [cnt_w-1:0]      count;
    logic [data_width-1:0] dout_q;
    logic                  push_err_q;
    logic                  pop_err_q;
    logic                  ovf_q;
    logic                  unf_q;

    logic                  full_c;
    logic                  empty_c;
    logic                  rd_acc_c;
    logic                  wr_acc_c;
    logic                  push_rej_c;
    logic                  pop_rej_c;
    logic [data_width-1:0] fwft_data_c;

    // Accept/reject decisions; flush suppresses all requests in its cycle.
    always_comb begin
        full_c      = (count == cnt_w'(depth));
        empty_c     = (count == '0);
        rd_acc_c    = rd_en_dp && !empty_c && !flush_dp;
        wr_acc_c    = wt_en_dp && (!full_c || rd_acc_c) && !flush_dp;
        push_rej_c  = wt_en_dp && !flush_dp && !wr_acc_c;
        pop_rej_c   = rd_en_dp && !flush_dp && empty_c;
        fwft_data_c = empty_c ? '0 : mem[rd_ptr];
    end

    // Storage array is deliberately left without reset.
    always_ff @(posedge clk_dp) begin
        if (rst_n_in_dp && wr_acc_c) begin
            mem[wr_ptr] <= data_in_dp;
        end
    end

    always_ff @(posedge clk_dp) begin
        if (!rst_n_in_dp) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_q     <= '0;
            push_err_q <= 1'b0;
            pop_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (flush_dp) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                dout_q     <= '0;
                push_err_q <= 1'b0;
                pop_err_q  <= 1'b0;
            end else begin
                if (wr_acc_c) begin
                    wr_ptr <= wr_ptr + addr_width'(1);
                end
                if (rd_acc_c) begin
                    rd_ptr <= rd_ptr + addr_width'(1);
                    dout_q <= mem[rd_ptr];
                end
                if (wr_acc_c && !rd_acc_c) begin
                    count <= count + cnt_w'(1);
                end else if (rd_acc_c && !wr_acc_c) begin
                    count <= count - cnt_w'(1);
                end
                push_err_q <= push_rej_c;
                pop_err_q  <= pop_rej_c;
            end
            // A new error wins over a coincident clear.
            ovf_q <= (ovf_q && !err_clr_dp) || push_rej_c;
            unf_q <= (unf_q && !err_clr_dp) || pop_rej_c;
        end
    end

    assign data_out_dp           = fwft_mode ? fwft_data_c : dout_q;
    assign fill_count_dp         = count;
    assign full_st_dp            = full_c;
    assign empty_st_dp           = empty_c;
    assign almost_full_dp        = (count >= af_thresh_dp);
    assign almost_empty_dp       = (count <= ae_thresh_dp);
    assign push_on_full_error_dp = push_err_q;
    assign pop_on_empty_error_dp = pop_err_q;
    assign overflow_sticky_dp    = ovf_q;
    assign underflow_sticky_dp   = unf_q;

endmodule

// File: tb/tb_fifo_sync_prog_dp.sv
// Bench for fifo_sync_prog_dp: standard and FWFT instances share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_fifo_sync_prog_dp;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          wt_en;
    logic          rd_en;
    logic          flush;
    logic          err_clr;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;

    logic [DW-1:0] dout_s, dout_f;
    logic [AW:0]   fill_s, fill_f;
    logic          full_s, full_f, empty_s, empty_f;
    logic          af_s, af_f, ae_s, ae_f;
    logic          perr_s, perr_f, uerr_s, uerr_f;
    logic          ovf_s, ovf_f, unf_s, unf_f;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    int   m_q[$];
    int   m_dout;
    bit   m_push_err, m_pop_err, m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_sync_prog_dp #(.data_width(DW), .addr_width(AW), .fwft_mode(1'b0)) dut_std (
        .clk_dp(clk), .rst_n_in_dp(rst_n), .data_in_dp(din), .wt_en_dp(wt_en),
        .rd_en_dp(rd_en), .flush_dp(flush), .err_clr_dp(err_clr),
        .af_thresh_dp(af_thresh), .ae_thresh_dp(ae_thresh),
        .data_out_dp(dout_s), .fill_count_dp(fill_s), .full_st_dp(full_s),
        .empty_st_dp(empty_s), .almost_full_dp(af_s), .almost_empty_dp(ae_s),
        .push_on_full_error_dp(perr_s), .pop_on_empty_error_dp(uerr_s),
        .overflow_sticky_dp(ovf_s), .underflow_sticky_dp(unf_s)
    );

    fifo_sync_prog_dp #(.data_width(DW), .addr_width(AW), .fwft_mode(1'b1)) dut_fwft (
        .clk_dp(clk), .rst_n_in_dp(rst_n), .data_in_dp(din), .wt_en_dp(wt_en),
        .rd_en_dp(rd_en), .flush_dp(flush), .err_clr_dp(err_clr),
        .af_thresh_dp(af_thresh), .ae_thresh_dp(ae_thresh),
        .data_out_dp(dout_f), .fill_count_dp(fill_f), .full_st_dp(full_f),
        .empty_st_dp(empty_f), .almost_full_dp(af_f), .almost_empty_dp(ae_f),
        .push_on_full_error_dp(perr_f), .pop_on_empty_error_dp(uerr_f),
        .overflow_sticky_dp(ovf_f), .underflow_sticky_dp(unf_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, using pre-edge state.
    task automatic model_edge(input logic r, input logic f, input logic w,
                              input logic rd, input logic c, input logic [DW-1:0] d);
        bit rd_ok, wr_ok, perr, uerr;
        int n;
        n = m_q.size();
        if (!r) begin
            m_q.delete();
            m_dout = 0; m_push_err = 0; m_pop_err = 0; m_ovf = 0; m_unf = 0;
        end else if (f) begin
            m_q.delete();
            m_dout = 0; m_push_err = 0; m_pop_err = 0;
            m_ovf = m_ovf && !c;
            m_unf = m_unf && !c;
        end else begin
            rd_ok = rd && (n > 0);
            wr_ok = w && ((n < DEPTH) || rd_ok);
            perr  = w && !wr_ok;
            uerr  = rd && (n == 0);
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(int'(d));
            m_push_err = perr;
            m_pop_err  = uerr;
            m_ovf = (m_ovf && !c) || perr;
            m_unf = (m_unf && !c) || uerr;
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        chk("fill_std",  32'(fill_s),  32'(n));
        chk("fill_fwft", 32'(fill_f),  32'(n));
        chk("full",      32'(full_s),  32'(n == DEPTH));
        chk("empty",     32'(empty_s), 32'(n == 0));
        chk("almost_full",  32'(af_s), 32'(n >= int'(af_thresh)));
        chk("almost_empty", 32'(ae_s), 32'(n <= int'(ae_thresh)));
        chk("push_err",  32'(perr_s),  32'(m_push_err));
        chk("pop_err",   32'(uerr_s),  32'(m_pop_err));
        chk("ovf_sticky", 32'(ovf_s),  32'(m_ovf));
        chk("unf_sticky", 32'(unf_s),  32'(m_unf));
        chk("dout_std",  32'(dout_s),  32'(m_dout));
        chk("dout_fwft", 32'(dout_f),  (n > 0) ? 32'(m_q[0]) : 32'h0);
        chk("flags_fwft", {28'h0, af_f, ae_f, perr_f, uerr_f},
            {28'h0, af_s, ae_s, perr_s, uerr_s});
        chk("sticky_fwft", {30'h0, ovf_f, unf_f}, {30'h0, ovf_s, unf_s});
    endtask

    task automatic step(input logic r, input logic f, input logic w,
                        input logic rd, input logic c, input logic [DW-1:0] d);
        rst_n = r; flush = f; wt_en = w; rd_en = rd; err_clr = c; din = d;
        @(posedge clk);
        model_edge(r, f, w, rd, c, d);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        af_thresh = 5'd16;
        ae_thresh = 5'd0;
        m_dout = 0; m_push_err = 0; m_pop_err = 0; m_ovf = 0; m_unf = 0;

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_empty", 32'(empty_s), 32'd1);
        chk("reset_dout",  32'(dout_s),  32'd0);

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
        chk("fill_16", 32'(fill_s), 32'd16);
        chk("full_16", 32'(full_s), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
        chk("overflow_pulse", 32'(perr_s), 32'd1);
        chk("overflow_sticky", 32'(ovf_s), 32'd1);
        idle();
        chk("overflow_pulse_gone", 32'(perr_s), 32'd0);

        // Drain in order, then underflow
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk("drain_data", 32'(dout_s), 32'(i));
        end
        chk("drain_empty", 32'(empty_s), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("underflow_pulse", 32'(uerr_s), 32'd1);
        chk("underflow_hold", 32'(dout_s), 32'h0F);
        chk("underflow_sticky", 32'(unf_s), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("err_clr_both", {30'h0, ovf_s, unf_s}, 32'd0);

        // Simultaneous push/pop on full and empty
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
        chk("full_rw_count", 32'(fill_s), 32'd16);
        chk("full_rw_head", 32'(dout_s), 32'h40);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("full_rw_tail", 32'(dout_s), 32'hA5);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
        chk("empty_rw_err", 32'(uerr_s), 32'd1);
        chk("empty_rw_count", 32'(fill_s), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Threshold flags
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
            chk("af_rise", 32'(af_s), 32'(i + 1 >= 12));
        end
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("ae_at_3", 32'(ae_s), 32'd1);
        af_thresh = 5'd2;
        idle();
        chk("af_low_thresh", 32'(af_s), 32'd1);
        af_thresh = 5'd17;
        idle();
        chk("af_thresh_17", 32'(af_s), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // FWFT visibility
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        chk("fwft_first_word", 32'(dout_f), 32'h3C);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft_pop_zero", 32'(dout_f), 32'h0);
        chk("fwft_pop_empty", 32'(empty_f), 32'd1);

        // Flush keeps stickies; reset mid-burst clears everything
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        chk("flush_count", 32'(fill_s), 32'd0);
        chk("flush_dout", 32'(dout_s), 32'd0);
        chk("flush_sticky", 32'(unf_s), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        chk("reset_burst_empty", 32'(empty_s), 32'd1);
        chk("reset_burst_sticky", 32'(unf_s), 32'd0);

        // Randomised traffic
        af_thresh = 5'd10;
        ae_thresh = 5'd4;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, f, w, rd, c;
            if ($urandom_range(0, 99) == 0) begin
                af_thresh = 5'($urandom_range(0, 17));
                ae_thresh = 5'($urandom_range(0, 17));
            end
            r  = ($urandom_range(0, 299) != 0);
            f  = ($urandom_range(0, 79) == 0);
            c  = ($urandom_range(0, 39) == 0);
            if ((cyc / 200) % 2 == 0) begin
                w  = ($urandom_range(0, 99) < 70);
                rd = ($urandom_range(0, 99) < 35);
            end else begin
                w  = ($urandom_range(0, 99) < 35);
                rd = ($urandom_range(0, 99) < 70);
            end
            step(r, f, w, rd, c, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_prog_dp.md
Name: fifo_sync_prog_dp

Overview:
- Single-clock, parametrised FIFO data path. It supersedes the fixed 4x16 FIFO data path for same-clock-domain buffering.
- Adds the following over that block:
  - configurable width and depth
  - run-time programmable almost-full and almost-empty thresholds
  - occupancy count output
  - selectable standard or first-word-fall-through (FWFT) read mode
  - synchronous flush
  - sticky error status alongside the one-cycle error pulses
- Sits between a producer and a consumer on the same clock in the data-path hierarchy.

Parameters:
- data_width, 8: word width in bits.
- addr_width, 4: pointer width; depth D = 2^addr_width words.
- fwft_mode, 0: 0 = standard read (1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk_dp  input  1  clock; all state updates on the rising edge.
- rst_n_in_dp  input  1  reset, synchronous, active-low.
- data_in_dp  input  data_width  write data.
- wt_en_dp  input  1  push request.
- rd_en_dp  input  1  pop request.
- flush_dp  input  1  synchronous flush; empties the FIFO.
- err_clr_dp  input  1  clears the sticky error bits.
- af_thresh_dp  input  addr_width+1  almost-full threshold.
- ae_thresh_dp  input  addr_width+1  almost-empty threshold.
- data_out_dp  output  data_width  read data.
- fill_count_dp  output  addr_width+1  occupancy, range 0..D.
- full_st_dp  output  1  fill_count_dp == D.
- empty_st_dp  output  1  fill_count_dp == 0.
- almost_full_dp  output  1  fill_count_dp >= af_thresh_dp.
- almost_empty_dp  output  1  fill_count_dp <= ae_thresh_dp.
- push_on_full_error_dp  output  1  one-cycle pulse on a rejected push.
- pop_on_empty_error_dp  output  1  one-cycle pulse on a rejected pop.
- overflow_sticky_dp  output  1  latched push_on_full_error_dp.
- underflow_sticky_dp  output  1  latched pop_on_empty_error_dp.

Behaviour:
- Reset (rst_n_in_dp=0 at a clock edge):
  - Pointers, count, data_out_dp, error pulses and sticky bits all go to 0.
  - Result: empty_st_dp=1, full_st_dp=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words from the next cycle.
- Priority: reset > flush_dp > rd/wt.
- Flush:
  - Pointers and count go to 0; data_out_dp goes to 0.
  - No error pulses are generated.
  - Sticky bits are unchanged.
  - rd/wt requests in the flush cycle are ignored.
- Write accepted when wt_en_dp=1 and (count<D, or a pop is accepted in the same cycle).
  - The word is stored at the write pointer, then the write pointer increments.
- Read accepted when rd_en_dp=1 and count>0 (count sampled before the edge).
  - The read pointer increments.
  - Same-cycle write data is never passed through to the read side.
- Push rejected (wt_en_dp=1, count==D, no accepted pop):
  - Nothing is stored and pointers are unchanged.
  - push_on_full_error_dp=1 for exactly the following cycle.
- Pop rejected (rd_en_dp=1, count==0):
  - Pointers and data_out_dp are unchanged.
  - pop_on_empty_error_dp=1 for the following cycle.
  - A simultaneous write is still accepted, giving count=1.
- Pointers wrap modulo D with no extra logic. Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Standard mode (fwft_mode=0): data_out_dp is registered.
  - On an accepted read it loads mem[rd_ptr] at that edge, so data is valid the cycle after rd_en_dp.
  - Otherwise it holds its value.
- FWFT mode (fwft_mode=1): data_out_dp = mem[rd_ptr] whenever count>0, and 0 when empty.
  - The first written word is visible the cycle after its write edge.
  - An accepted read advances the output to the next word in the following cycle.
- Flags and fill_count_dp:
  - All are derived from the registered count, so they change in the cycle after the causing edge.
  - Thresholds are compared continuously and may change at any time.
  - af_thresh_dp=0 makes almost_full_dp always 1; af_thresh_dp>D makes it never assert.
  - ae_thresh_dp>=D makes almost_empty_dp always 1.
- Sticky bits:
  - Each is set in the same cycle as its pulse and held until err_clr_dp=1 or reset.
  - If err_clr_dp=1 coincides with a new error, set wins.

Test Plan (data_width=8, addr_width=4, D=16, fwft_mode=0 unless stated):
- Reset then 16 writes of 0x00..0x0F, no reads -> fill_count_dp=16, full_st_dp=1 a cycle after the 16th write. A 17th write -> push_on_full_error_dp pulses 1 cycle, overflow_sticky_dp=1, count stays 16.
- Drain all 16 with rd_en_dp held -> data_out_dp sequence 0x00..0x0F, each 1 cycle after its read. empty_st_dp=1 after the last read. One more rd -> pop_on_empty_error_dp pulse, data_out_dp holds 0x0F, underflow_sticky_dp=1.
- Full FIFO with wt_en_dp=rd_en_dp=1 and data 0xA5 -> count stays 16, head popped, 0xA5 stored. Empty FIFO with both asserted -> pop error pulse, count=1.
- af_thresh_dp=12, ae_thresh_dp=3, fill to 12 -> almost_full_dp rises exactly when count reaches 12. Draining to 3 -> almost_empty_dp=1. Changing af_thresh_dp to 17 -> almost_full_dp=0 next cycle.
- fwft_mode=1: write 0x3C into empty FIFO -> data_out_dp=0x3C the next cycle with no rd. Pop -> data_out_dp=0 and empty_st_dp=1.
- Write 5 words, then flush_dp=1 with wt_en_dp=1 -> count=0, data_out_dp=0, stickies unchanged. Assert rst_n_in_dp=0 during a burst -> all outputs 0, empty_st_dp=1 next cycle. err_clr_dp clears both stickies.
